// File: rtl/pitch_pkg.sv
// Shared types and default sizing for the pitch-detection path.
package pitch_pkg;

    localparam int N_SAMPLES  = 64;
    localparam int OUT_W      = 16;
    localparam int ADC_W      = 12;
    localparam int SAMPLE_DIV = 50000;

    typedef logic [OUT_W-1:0] sample_t;
    typedef sample_t [N_SAMPLES-1:0] frame_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } framer_state_e;

endpackage

// File: rtl/tick_divider.sv
// Free-running divider producing a registered one-cycle tick every DIV clocks.
module tick_divider #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] div_q;
    logic          tick_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= (div_q == LAST);
            div_q  <= (div_q == LAST) ? '0 : div_q + 1'b1;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/sample_framer.sv
// Decimates the mic ADC stream, formats samples and hands N-sample frames to the FFT,
// holding each accepted frame until the FFT signals done.
module sample_framer #(
    parameter int N_SAMPLES  = pitch_pkg::N_SAMPLES,
    parameter int SAMPLE_DIV = pitch_pkg::SAMPLE_DIV,
    parameter int ADC_W      = pitch_pkg::ADC_W,
    parameter int OUT_W      = pitch_pkg::OUT_W,
    parameter int REMOVE_DC  = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADC_W-1:0]           adc_data,
    input  logic                       fft_done,
    output logic [N_SAMPLES*OUT_W-1:0] frame,
    output logic                       fft_start,
    output logic                       fft_busy,
    output logic                       sample_tick,
    output logic [7:0]                 overrun_cnt
);

    import pitch_pkg::*;

    localparam int CNT_W = $clog2(N_SAMPLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SAMPLES - 1);

    logic [ADC_W-1:0] adc_meta_q, adc_s_q;
    logic             tick;
    logic [6:0]       x_top;
    logic             fmt_sign;
    logic [OUT_W-1:0] fmt;
    logic [OUT_W-1:0] cap_q  [N_SAMPLES];
    logic [OUT_W-1:0] hold_q [N_SAMPLES];
    logic [CNT_W-1:0] cnt_q;
    logic             frame_complete;

    framer_state_e state_q, state_d;
    logic          start_q, start_d;
    logic          load_d;
    logic [7:0]    ovr_q, ovr_d;

    tick_divider #(.DIV(SAMPLE_DIV)) u_tick_divider (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // adc_data is only slowly varying, so a plain two-flop sync is enough
    always_ff @(posedge clk) begin
        if (reset) begin
            adc_meta_q <= '0;
            adc_s_q    <= '0;
        end else begin
            adc_meta_q <= adc_data;
            adc_s_q    <= adc_meta_q;
        end
    end

    // Subtracting midscale only flips the MSB, so the top seven bits are all we need
    assign x_top    = {adc_s_q[ADC_W-1] ^ (REMOVE_DC != 0), adc_s_q[ADC_W-2 -: 6]};
    assign fmt_sign = (REMOVE_DC != 0) ? x_top[6] : 1'b0;
    assign fmt      = {fmt_sign, x_top, {(OUT_W-8){1'b0}}};

    generate
        if (ADC_W > 7) begin : g_lsbs
            logic unused_lsbs;
            assign unused_lsbs = ^adc_s_q[ADC_W-8:0];
        end
    endgenerate

    assign frame_complete = tick && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_SAMPLES; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (reset) begin
                    cap_q[gi]  <= '0;
                    hold_q[gi] <= '0;
                end else begin
                    if (tick) begin
                        cap_q[gi] <= (gi == 0) ? fmt : cap_q[(gi == 0) ? 0 : gi-1];
                    end
                    if (load_d) begin
                        hold_q[gi] <= (gi == 0) ? fmt : cap_q[(gi == 0) ? 0 : gi-1];
                    end
                end
            end
            assign frame[gi*OUT_W +: OUT_W] = hold_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            ovr_q   <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            ovr_q   <= ovr_d;
        end
    end

    // A frame completing on the same cycle the FFT finishes is taken, not dropped
    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        load_d  = 1'b0;
        ovr_d   = ovr_q;
        case (state_q)
            IDLE: begin
                if (frame_complete) begin
                    load_d  = 1'b1;
                    start_d = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (frame_complete && fft_done) begin
                    load_d  = 1'b1;
                    start_d = 1'b1;
                end else if (fft_done) begin
                    state_d = IDLE;
                end else if (frame_complete && (ovr_q != 8'hFF)) begin
                    ovr_d = ovr_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fft_start   = start_q;
    assign fft_busy    = (state_q == BUSY);
    assign sample_tick = tick;
    assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_sample_framer.sv
// Randomized bench for sample_framer (N=4, DIV=4) against a frame-level reference model.
module tb_sample_framer;

    localparam int N   = 4;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] adc_data = '0;
    logic        fft_done = 1'b0;

    logic [63:0] frame0, frame1;
    logic        start0, start1, busy0, busy1, tick0, tick1;
    logic [7:0]  ovr0, ovr1;

    always #5 clk = ~clk;

    sample_framer #(.N_SAMPLES(N), .SAMPLE_DIV(DIV), .ADC_W(12), .OUT_W(16), .REMOVE_DC(0)) dut0 (
        .clk(clk), .reset(reset), .adc_data(adc_data), .fft_done(fft_done),
        .frame(frame0), .fft_start(start0), .fft_busy(busy0),
        .sample_tick(tick0), .overrun_cnt(ovr0)
    );

    sample_framer #(.N_SAMPLES(N), .SAMPLE_DIV(DIV), .ADC_W(12), .OUT_W(16), .REMOVE_DC(1)) dut1 (
        .clk(clk), .reset(reset), .adc_data(adc_data), .fft_done(fft_done),
        .frame(frame1), .fft_start(start1), .fft_busy(busy1),
        .sample_tick(tick1), .overrun_cnt(ovr1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model state: edge count since reset release, samples captured, history
    int          e;
    bit          tick_prev;
    int          samples;
    bit          busy_m;
    int          ovr_m;
    int          starts;
    logic [11:0] hist[$];
    logic [11:0] pending;
    logic [63:0] fexp0, fexp1;
    int          adc_mode;
    int          done_mode;

    function automatic logic [15:0] fmt0(input logic [11:0] a);
        return 16'((int'(a) >> 5) << 8);
    endfunction

    function automatic logic [15:0] fmt1(input logic [11:0] a);
        int x, q;
        x = int'(a) - 2048;
        q = x >>> 5;
        return 16'((q & 255) << 8);
    endfunction

    function automatic logic [63:0] build(input bit dc);
        logic [63:0] f;
        f = '0;
        for (int k = 0; k < N; k++)
            f[k*16 +: 16] = dc ? fmt1(hist[k]) : fmt0(hist[k]);
        return f;
    endfunction

    function automatic logic [11:0] next_adc();
        case (adc_mode)
            1:       return 12'(((samples + 1) % N) * 32);
            2:       return 12'($urandom_range(0, 4095));
            default: return adc_data;
        endcase
    endfunction

    task automatic step();
        bit done_in, comp, start_exp;
        case (done_mode)
            1:       done_in = ($urandom_range(0, 5) == 0);
            2:       done_in = tick_prev && (((samples + 1) % N) == 0);
            3:       done_in = busy_m;
            default: done_in = 1'b0;
        endcase
        fft_done = done_in;
        @(posedge clk);
        #1;
        fft_done = 1'b0;
        e++;
        comp = 1'b0;
        start_exp = 1'b0;
        if (tick_prev) begin
            hist.push_front(pending);
            if (hist.size() > N) void'(hist.pop_back());
            samples++;
            comp = ((samples % N) == 0);
        end
        if (comp && (!busy_m || done_in)) begin
            start_exp = 1'b1;
            busy_m = 1'b1;
            fexp0 = build(1'b0);
            fexp1 = build(1'b1);
        end else if (comp) begin
            if (ovr_m < 255) ovr_m++;
        end else if (done_in && busy_m) begin
            busy_m = 1'b0;
        end
        tick_prev = ((e % DIV) == 0);

        check("tick0", tick0, tick_prev);
        check("start0", start0, start_exp);
        check("busy0", busy0, busy_m);
        check("ovr0", ovr0, 64'(ovr_m));
        check("frame0", frame0, fexp0);
        check("tick1", tick1, tick_prev);
        check("start1", start1, start_exp);
        check("busy1", busy1, busy_m);
        check("ovr1", ovr1, 64'(ovr_m));
        check("frame1", frame1, fexp1);

        if (start_exp) begin
            starts++;
            $display("frame accepted edge=%0d frame=%h dc_frame=%h overruns=%0d", e, fexp0, fexp1, ovr_m);
        end
        if (tick_prev) begin
            pending = adc_data;
            adc_data = next_adc();
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        fft_done = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_frame0", frame0, 64'h0);
        check("rst_frame1", frame1, 64'h0);
        check("rst_start", {start0, start1}, 2'b00);
        check("rst_busy", {busy0, busy1}, 2'b00);
        check("rst_tick", {tick0, tick1}, 2'b00);
        check("rst_ovr", {ovr0, ovr1}, 16'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        e = 0;
        tick_prev = 1'b0;
        samples = 0;
        busy_m = 1'b0;
        ovr_m = 0;
        starts = 0;
        hist.delete();
        fexp0 = '0;
        fexp1 = '0;
        pending = '0;
    endtask

    initial begin
        int  first_tick;
        bit  reached;

        // Constant full-scale input: first tick timing and a 7F00-filled frame
        adc_mode = 0; done_mode = 0; adc_data = 12'hFFF;
        do_reset();
        first_tick = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tick0 && first_tick < 0) first_tick = e;
        end
        check("t1_first_tick_edge", 64'(first_tick), 64'd4);
        check("t1_starts", 64'(starts), 64'd1);
        check("t1_frame", frame0, {4{16'h7F00}});
        check("t1_busy", busy0, 1'b1);

        // Ramp input: slot 0 holds the newest sample
        adc_mode = 1; done_mode = 3; adc_data = 12'h000;
        do_reset();
        run(20);
        check("t2_starts", 64'(starts), 64'd1);
        check("t2_frame", frame0, 64'h0000_0100_0200_0300);
        check("t2_dc_frame", frame1, 64'hC000_C100_C200_C300);

        // FFT never finishes: later frames dropped and counted
        adc_mode = 2; done_mode = 0; adc_data = 12'(($urandom_range(0, 4095)));
        do_reset();
        run(52);
        check("t3_starts", 64'(starts), 64'd1);
        check("t3_overruns", ovr0, 8'd2);
        check("t3_frame_held", frame0, fexp0);

        // fft_done coincident with the completing tick: accepted, no overrun
        done_mode = 2;
        run(32);
        check("t4_starts", 64'(starts), 64'd3);
        check("t4_overruns", ovr0, 8'd2);
        check("t4_busy", busy0, 1'b1);

        // Reset in BUSY with two samples into the next frame
        done_mode = 0;
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            step();
            reached = busy_m && ((samples % N) == 2);
        end
        check("t5_reached_cnt2", reached, 1'b1);
        do_reset();
        run(16);
        check("t5_no_early_start", 64'(starts), 64'd0);
        step();
        check("t5_start_after_4_ticks", start0, 1'b1);

        // Midscale removal: 000 -> C000, 800 -> 0000
        adc_mode = 0; done_mode = 3; adc_data = 12'h000;
        do_reset();
        run(20);
        check("t6_dc_low", frame1, {4{16'hC000}});
        adc_data = 12'h800;
        run(32);
        check("t6_dc_mid", frame1, 64'h0);
        check("t6_plain_mid", frame0, {4{16'h4000}});

        // Random data and random fft_done pulses
        adc_mode = 2; done_mode = 1;
        do_reset();
        run(600);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
